// File: rtl/as_sdc_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : as_sdc_supervisor
//  Purpose  : AS-side SDC close request, watchdog kick and fault supervision.
//  Revision : 1.0  initial release
// ============================================================================
module as_sdc_supervisor #(
    parameter int WD_HALF_PERIOD = 2500,
    parameter int CLOSE_TIMEOUT  = 50000,
    parameter int HB_TIMEOUT     = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       as_ready_req,
    input  logic       as_emergency,
    input  logic       heartbeat,
    input  logic       fault_clear,
    input  logic       sdc_is_ready,
    input  logic       sdc_closed_fb,
    output logic       as_close_sdc,
    output logic       watchdog_out,
    output logic [1:0] state,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int c_TMO_W = (CLOSE_TIMEOUT > 1) ? $clog2(CLOSE_TIMEOUT) : 1;
    localparam int c_HB_W  = $clog2(HB_TIMEOUT + 1);
    localparam int c_WD_W  = (WD_HALF_PERIOD > 1) ? $clog2(WD_HALF_PERIOD) : 1;

    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(CLOSE_TIMEOUT - 1);
    localparam logic [c_HB_W-1:0]  c_HB_MAX   = c_HB_W'(HB_TIMEOUT);
    localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(WD_HALF_PERIOD - 1);

    localparam logic [2:0] c_FC_NONE  = 3'd0;
    localparam logic [2:0] c_FC_EMERG = 3'd1;
    localparam logic [2:0] c_FC_HB    = 3'd2;
    localparam logic [2:0] c_FC_OPEN  = 3'd3;
    localparam logic [2:0] c_FC_TMO   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMING = 2'd1,
        ST_CLOSED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_close;
    logic               r_fault;
    logic [2:0]         r_code;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               r_rdy_m, r_rdy_s, r_fb_m, r_fb_s;
    logic               r_hb_d;
    logic [c_HB_W-1:0]  r_hb_cnt;
    logic [c_WD_W-1:0]  r_wd_cnt;
    logic               r_wd;

    logic               w_hb_rise;
    logic               w_hb_ok;
    logic               w_wd_en;
    logic [2:0]         w_fault_code;

    assign w_hb_rise = heartbeat & ~r_hb_d;
    assign w_hb_ok   = (r_hb_cnt != c_HB_MAX);
    assign w_wd_en   = w_hb_ok && (r_state != ST_FAULT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy_m <= 1'b0;
            r_rdy_s <= 1'b0;
            r_fb_m  <= 1'b0;
            r_fb_s  <= 1'b0;
        end else begin
            r_rdy_m <= sdc_is_ready;
            r_rdy_s <= r_rdy_m;
            r_fb_m  <= sdc_closed_fb;
            r_fb_s  <= r_fb_m;
        end
    end

    // Counter saturates at HB_TIMEOUT; the saturated value itself means "lost".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hb_d   <= 1'b0;
            r_hb_cnt <= '0;
        end else begin
            r_hb_d <= heartbeat;
            if (w_hb_rise)
                r_hb_cnt <= '0;
            else if (r_hb_cnt != c_HB_MAX)
                r_hb_cnt <= r_hb_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd_cnt <= '0;
            r_wd     <= 1'b0;
        end else if (!w_wd_en) begin
            r_wd_cnt <= '0;
            r_wd     <= 1'b0;
        end else if (r_wd_cnt == c_WD_LAST) begin
            r_wd_cnt <= '0;
            r_wd     <= ~r_wd;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    // Highest-priority fault among the events that apply while the SDC is requested closed.
    always_comb begin
        w_fault_code = c_FC_NONE;
        if (r_state == ST_ARMING || r_state == ST_CLOSED) begin
            if (as_emergency)
                w_fault_code = c_FC_EMERG;
            else if (!w_hb_ok)
                w_fault_code = c_FC_HB;
            else if (r_state == ST_CLOSED && !r_fb_s)
                w_fault_code = c_FC_OPEN;
            else if (r_state == ST_ARMING && !r_fb_s && r_tmo_cnt == c_TMO_LAST)
                w_fault_code = c_FC_TMO;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_close   <= 1'b0;
            r_fault   <= 1'b0;
            r_code    <= c_FC_NONE;
            r_tmo_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (as_ready_req && w_hb_ok && r_rdy_s && !as_emergency) begin
                        r_state   <= ST_ARMING;
                        r_close   <= 1'b1;
                        r_tmo_cnt <= '0;
                    end
                end
                ST_ARMING, ST_CLOSED: begin
                    if (w_fault_code != c_FC_NONE) begin
                        r_state <= ST_FAULT;
                        r_close <= 1'b0;
                        r_fault <= 1'b1;
                        r_code  <= w_fault_code;
                    end else if (!as_ready_req) begin
                        r_state <= ST_IDLE;
                        r_close <= 1'b0;
                    end else if (r_state == ST_ARMING) begin
                        if (r_fb_s)
                            r_state <= ST_CLOSED;
                        else
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (fault_clear && !as_ready_req && !as_emergency) begin
                        r_state <= ST_IDLE;
                        r_fault <= 1'b0;
                        r_code  <= c_FC_NONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_close <= 1'b0;
                end
            endcase
        end
    end

    assign as_close_sdc = r_close;
    assign watchdog_out = r_wd;
    assign state        = r_state;
    assign fault        = r_fault;
    assign fault_code   = r_code;

endmodule
`default_nettype wire

// File: tb/tb_as_sdc_supervisor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_as_sdc_supervisor
//  Purpose  : Directed plus randomized bench against a cycle-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_as_sdc_supervisor;

    localparam int WD = 4;
    localparam int CT = 20;
    localparam int HB = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       as_ready_req, as_emergency, heartbeat, fault_clear;
    logic       sdc_is_ready, sdc_closed_fb;
    logic       as_close_sdc, watchdog_out, fault;
    logic [1:0] state;
    logic [2:0] fault_code;

    always #5 clk = ~clk;

    as_sdc_supervisor #(
        .WD_HALF_PERIOD (WD),
        .CLOSE_TIMEOUT  (CT),
        .HB_TIMEOUT     (HB)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .as_ready_req  (as_ready_req),
        .as_emergency  (as_emergency),
        .heartbeat     (heartbeat),
        .fault_clear   (fault_clear),
        .sdc_is_ready  (sdc_is_ready),
        .sdc_closed_fb (sdc_closed_fb),
        .as_close_sdc  (as_close_sdc),
        .watchdog_out  (watchdog_out),
        .state         (state),
        .fault         (fault),
        .fault_code    (fault_code)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: state as 0..3, time-since-events as plain integers.
    int m_state, m_code, m_arm, m_since, m_wd_run;
    bit m_hb_prev, m_rdy1, m_rdy2, m_fb1, m_fb2;

    // Stimulus helpers for the heartbeat generator.
    bit hb_en;
    int hb_ph;

    task automatic model_reset();
        m_state = 0; m_code = 0; m_arm = 0; m_since = 0; m_wd_run = 0;
        m_hb_prev = 0; m_rdy1 = 0; m_rdy2 = 0; m_fb1 = 0; m_fb2 = 0;
    endtask

    task automatic model_edge();
        bit ok;
        int st;
        int c;
        ok = (m_since < HB);
        st = m_state;
        c  = 0;
        case (st)
            0: if (as_ready_req && ok && m_rdy2 && !as_emergency) begin
                   m_state = 1;
                   m_arm   = 0;
               end
            1, 2: begin
                if (st == 1) m_arm++;
                if (as_emergency)                          c = 1;
                else if (!ok)                              c = 2;
                else if (st == 2 && !m_fb2)                c = 3;
                else if (st == 1 && !m_fb2 && m_arm == CT) c = 4;
                if (c != 0) begin
                    m_state = 3;
                    m_code  = c;
                end else if (!as_ready_req) begin
                    m_state = 0;
                end else if (st == 1 && m_fb2) begin
                    m_state = 2;
                end
            end
            default: if (fault_clear && !as_ready_req && !as_emergency) begin
                m_state = 0;
                m_code  = 0;
            end
        endcase
        if (ok && st != 3) m_wd_run++;
        else               m_wd_run = 0;
        if (heartbeat && !m_hb_prev) m_since = 0;
        else if (m_since < HB)       m_since++;
        m_hb_prev = heartbeat;
        m_rdy2 = m_rdy1; m_rdy1 = sdc_is_ready;
        m_fb2  = m_fb1;  m_fb1  = sdc_closed_fb;
    endtask

    task automatic compare_all();
        check_val("state",        state,        m_state);
        check_val("as_close_sdc", as_close_sdc, (m_state == 1 || m_state == 2));
        check_val("fault",        fault,        (m_state == 3));
        check_val("fault_code",   fault_code,   m_code);
        check_val("watchdog_out", watchdog_out, (m_wd_run / WD) % 2);
    endtask

    // One clock: model follows the edge, DUT sampled on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
        if (hb_en) begin
            hb_ph++;
            if (hb_ph >= 10) begin
                heartbeat = ~heartbeat;
                hb_ph     = 0;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic pulse_clear();
        fault_clear = 1'b1;
        cycle();
        fault_clear = 1'b0;
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check_val("rst_state", state,        0);
        check_val("rst_close", as_close_sdc, 0);
        check_val("rst_wd",    watchdog_out, 0);
        check_val("rst_fault", fault,        0);
        check_val("rst_code",  fault_code,   0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        as_ready_req = 0; as_emergency = 0; heartbeat = 0; fault_clear = 0;
        sdc_is_ready = 0; sdc_closed_fb = 0;
        hb_en = 1; hb_ph = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run(15);
        do_reset();
        run(20);

        // Arm, close, then emergency coinciding with feedback loss.
        sdc_is_ready = 1; as_ready_req = 1;
        run(5);
        sdc_closed_fb = 1;
        run(6);
        as_emergency = 1; sdc_closed_fb = 0;
        cycle();
        as_emergency = 0;
        run(3);
        pulse_clear();
        run(3);
        as_ready_req = 0;
        pulse_clear();
        run(10);

        // Close timeout with no feedback.
        as_ready_req = 1;
        run(28);
        as_ready_req = 0;
        run(2);
        pulse_clear();
        run(5);

        // Heartbeat loss while closed.
        as_ready_req = 1;
        run(4);
        sdc_closed_fb = 1;
        run(6);
        hb_en = 0;
        run(40);
        hb_en = 1; as_ready_req = 0; sdc_closed_fb = 0;
        run(12);
        pulse_clear();
        run(5);

        // Heartbeat loss while idle: arming blocked, no fault.
        hb_en = 0;
        run(40);
        as_ready_req = 1;
        run(10);
        hb_en = 1;
        run(25);
        as_ready_req = 0;
        run(5);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) as_ready_req = ~as_ready_req;
            as_emergency = ($urandom_range(0, 149) == 0);
            fault_clear  = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 59) == 0) sdc_is_ready = ~sdc_is_ready;
            if (m_state == 1 || m_state == 2) begin
                if (!sdc_closed_fb && $urandom_range(0, 14) == 0) sdc_closed_fb = 1;
                else if (sdc_closed_fb && $urandom_range(0, 299) == 0) sdc_closed_fb = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                sdc_closed_fb = 0;
            end
            if (hb_en && $urandom_range(0, 399) == 0) hb_en = 0;
            else if (!hb_en && $urandom_range(0, 39) == 0) hb_en = 1;
            if ($urandom_range(0, 999) == 0) do_reset();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
